// File: rtl/ads8556_emu_if.sv
// ADS8556 host bus: CONVST, strobes, reset/standby pins, data bus, BUSY.
// master = host side, slave = emulator side.
interface ads8556_emu_if;
    logic        adc_conv;
    logic        adc_csn;
    logic        adc_rdn;
    logic        adc_wrn;
    logic        adc_standbyn;
    logic        adc_reset;
    logic [15:0] adc_data_in;
    logic [15:0] adc_data_out;
    logic        adc_data_t;
    logic        adc_busy;

    modport master (
        output adc_conv, adc_csn, adc_rdn, adc_wrn,
        output adc_standbyn, adc_reset, adc_data_in,
        input  adc_data_out, adc_data_t, adc_busy
    );

    modport slave (
        input  adc_conv, adc_csn, adc_rdn, adc_wrn,
        input  adc_standbyn, adc_reset, adc_data_in,
        output adc_data_out, adc_data_t, adc_busy
    );
endinterface

// File: rtl/ads8556_emu.sv
// ADS8556 emulator: CONVST/BUSY timing, six-channel readback, config writes.
// Ports: clk/rst, bus (slave modport), ch0..ch5 samples, cfg_reg/cfg_valid, conv_drop.
module ads8556_emu #(
    parameter int          CLK_FREQ    = 100_000_000,
    parameter int          CONV_CYCLES = 200,
    parameter logic [31:0] CFG_DEFAULT = 32'h0000_03FF
) (
    input  logic                clk,
    input  logic                rst,
    ads8556_emu_if.slave        bus,
    input  logic [15:0]         ch0,
    input  logic [15:0]         ch1,
    input  logic [15:0]         ch2,
    input  logic [15:0]         ch3,
    input  logic [15:0]         ch4,
    input  logic [15:0]         ch5,
    output logic [31:0]         cfg_reg,
    output logic                cfg_valid,
    output logic                conv_drop
);

    if (CONV_CYCLES < 4 || CONV_CYCLES > 65535 || CLK_FREQ <= 0) begin : g_bad_param
        $error("ads8556_emu: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LOAD = 16'(CONV_CYCLES - 1);
    // bit order: conv, csn, rdn, wrn, standbyn, reset; standbyn idles high
    localparam logic [5:0]  SYNC_RST = 6'b000010;

    logic [5:0]  meta_q, meta_d;
    logic [5:0]  sync_q, sync_d;
    logic [2:0]  prev_q, prev_d;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [15:0] shadow_q [0:5];
    logic [15:0] shadow_d [0:5];
    logic [31:0] cfg_q, cfg_d;
    logic        word_q, word_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic        data_t_q, data_t_d;
    logic [15:0] data_out_q, data_out_d;

    logic conv_s, csn_s, rdn_s, wrn_s, stby_s, devrst_s;
    logic conv_rise, rdn_rise, wrn_rise, rd_act;

    assign conv_s   = sync_q[5];
    assign csn_s    = sync_q[4];
    assign rdn_s    = sync_q[3];
    assign wrn_s    = sync_q[2];
    assign stby_s   = sync_q[1];
    assign devrst_s = sync_q[0];

    assign conv_rise = conv_s & ~prev_q[2];
    assign rdn_rise  = rdn_s & ~prev_q[1];
    assign wrn_rise  = wrn_s & ~prev_q[0];
    assign rd_act    = ~csn_s & ~rdn_s;

    always_comb begin
        meta_d = {bus.adc_conv, bus.adc_csn, bus.adc_rdn,
                  bus.adc_wrn, bus.adc_standbyn, bus.adc_reset};
        sync_d = meta_q;
        prev_d = {conv_s, rdn_s, wrn_s};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        shadow_d   = shadow_q;
        cfg_d      = cfg_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        drop_d     = 1'b0;
        data_t_d   = ~rd_act;
        data_out_d = rd_act ? shadow_q[ptr_q] : 16'h0000;

        if (~csn_s & rdn_rise) begin
            ptr_d = (ptr_q == 3'd5) ? 3'd0 : ptr_q + 3'd1;
        end

        // a write edge counts only if rdn stayed high across it
        if (~csn_s & wrn_rise & rdn_s & prev_q[1]) begin
            if (!word_q) begin
                cfg_d[31:16] = bus.adc_data_in;
                word_d       = 1'b1;
            end else begin
                cfg_d[15:0] = bus.adc_data_in;
                word_d      = 1'b0;
                valid_d     = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE, S_READY: begin
                if (conv_rise) begin
                    if (stby_s) begin
                        state_d = S_CONV;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_LOAD;
                        word_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_CONV: begin
                if (conv_rise) begin
                    drop_d = 1'b1;
                end
                if (!stby_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == 16'd0) begin
                    state_d     = S_READY;
                    busy_d      = 1'b0;
                    ptr_d       = 3'd0;
                    shadow_d[0] = ch0;
                    shadow_d[1] = ch1;
                    shadow_d[2] = ch2;
                    shadow_d[3] = ch3;
                    shadow_d[4] = ch4;
                    shadow_d[5] = ch5;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // device reset pin: everything but the synchronizers
        if (devrst_s) begin
            state_d    = S_IDLE;
            cnt_d      = 16'd0;
            busy_d     = 1'b0;
            ptr_d      = 3'd0;
            cfg_d      = CFG_DEFAULT;
            word_d     = 1'b0;
            valid_d    = 1'b0;
            drop_d     = 1'b0;
            data_t_d   = 1'b1;
            data_out_d = 16'h0000;
            for (int i = 0; i < 6; i++) begin
                shadow_d[i] = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= SYNC_RST;
            sync_q     <= SYNC_RST;
            prev_q     <= 3'b000;
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            busy_q     <= 1'b0;
            ptr_q      <= 3'd0;
            cfg_q      <= CFG_DEFAULT;
            word_q     <= 1'b0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
            data_t_q   <= 1'b1;
            data_out_q <= 16'h0000;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= 16'h0000;
            end
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            cfg_q      <= cfg_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            data_t_q   <= data_t_d;
            data_out_q <= data_out_d;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign bus.adc_busy     = busy_q;
    assign bus.adc_data_t   = data_t_q;
    assign bus.adc_data_out = data_out_q;
    assign cfg_reg          = cfg_q;
    assign cfg_valid        = valid_q;
    assign conv_drop        = drop_q;

endmodule

// File: tb/tb_ads8556_emu.sv
// Directed bench for ads8556_emu: conversion timing, readback, writes,
// standby, device reset and system reset.
module tb_ads8556_emu;

    logic        clk;
    logic        rst;
    logic [15:0] ch0, ch1, ch2, ch3, ch4, ch5;
    logic [31:0] cfg_reg;
    logic        cfg_valid;
    logic        conv_drop;

    int checks;
    int failures;
    int valid_cnt;
    int drop_cnt;

    ads8556_emu_if bus ();

    ads8556_emu #(
        .CLK_FREQ    (100_000_000),
        .CONV_CYCLES (200),
        .CFG_DEFAULT (32'h0000_03FF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ch0       (ch0),
        .ch1       (ch1),
        .ch2       (ch2),
        .ch3       (ch3),
        .ch4       (ch4),
        .ch5       (ch5),
        .cfg_reg   (cfg_reg),
        .cfg_valid (cfg_valid),
        .conv_drop (conv_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_valid) valid_cnt++;
        if (conv_drop) drop_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_read(output logic [15:0] d, output logic t);
        bus.adc_csn = 1'b0;
        tick(1);
        bus.adc_rdn = 1'b0;
        tick(4);
        d = bus.adc_data_out;
        t = bus.adc_data_t;
        bus.adc_rdn = 1'b1;
        tick(4);
        bus.adc_csn = 1'b1;
        tick(4);
    endtask

    task automatic do_write(input logic [15:0] v);
        bus.adc_csn     = 1'b0;
        bus.adc_data_in = v;
        tick(1);
        bus.adc_wrn = 1'b0;
        tick(4);
        bus.adc_wrn = 1'b1;
        tick(4);
        bus.adc_csn = 1'b1;
        tick(4);
    endtask

    task automatic conv_start(input string tag);
        bus.adc_conv = 1'b1;
        tick(3);
        bus.adc_conv = 1'b0;
        chk(tag, {31'd0, bus.adc_busy}, 32'd1);
    endtask

    task automatic run_conv(input string tag);
        int n;
        conv_start(tag);
        n = 0;
        while (bus.adc_busy && n < 400) begin
            n++;
            tick(1);
        end
        chk({tag, "_len"}, n, 32'd200);
    endtask

    logic [15:0] rd;
    logic        rt;
    logic [15:0] exp_rd [0:6];
    int          n;
    int          m;
    int          d0;

    initial begin
        checks    = 0;
        failures  = 0;
        valid_cnt = 0;
        drop_cnt  = 0;
        rst = 1'b1;
        bus.adc_conv      = 1'b0;
        bus.adc_csn       = 1'b1;
        bus.adc_rdn       = 1'b1;
        bus.adc_wrn       = 1'b1;
        bus.adc_standbyn  = 1'b1;
        bus.adc_reset     = 1'b0;
        bus.adc_data_in   = 16'h0000;
        ch0 = 16'h1111; ch1 = 16'h2222; ch2 = 16'h3333;
        ch3 = 16'h4444; ch4 = 16'h5555; ch5 = 16'h6666;
        exp_rd[0] = 16'h1111; exp_rd[1] = 16'h2222;
        exp_rd[2] = 16'h3333; exp_rd[3] = 16'h4444;
        exp_rd[4] = 16'h5555; exp_rd[5] = 16'h6666;
        exp_rd[6] = 16'h1111;

        tick(3);
        chk("rst_busy", {31'd0, bus.adc_busy}, 32'd0);
        chk("rst_data_t", {31'd0, bus.adc_data_t}, 32'd1);
        chk("rst_data_out", {16'd0, bus.adc_data_out}, 32'd0);
        chk("rst_cfg", cfg_reg, 32'h0000_03FF);
        rst = 1'b0;
        tick(6);
        chk("idle_data_t", {31'd0, bus.adc_data_t}, 32'd1);

        run_conv("conv1");
        for (int i = 0; i < 7; i++) begin
            do_read(rd, rt);
            chk($sformatf("rd%0d_t", i), {31'd0, rt}, 32'd0);
            chk($sformatf("rd%0d", i), {16'd0, rd}, {16'd0, exp_rd[i]});
        end

        d0 = drop_cnt;
        conv_start("conv2");
        n = 0;
        while (bus.adc_busy && n < 400) begin
            if (n == 50) bus.adc_conv = 1'b1;
            if (n == 54) bus.adc_conv = 1'b0;
            n++;
            tick(1);
        end
        chk("conv2_len", n, 32'd200);
        chk("conv2_drop", drop_cnt - d0, 32'd1);

        do_write(16'hABCD);
        chk("cfg_hi", cfg_reg, 32'hABCD_03FF);
        chk("valid_none", valid_cnt, 32'd0);
        do_write(16'h1234);
        chk("cfg_full", cfg_reg, 32'hABCD_1234);
        chk("valid_once", valid_cnt, 32'd1);

        bus.adc_csn     = 1'b0;
        bus.adc_data_in = 16'hFFFF;
        tick(1);
        bus.adc_rdn = 1'b0;
        bus.adc_wrn = 1'b0;
        tick(4);
        chk("rw_data_t", {31'd0, bus.adc_data_t}, 32'd0);
        chk("rw_data", {16'd0, bus.adc_data_out}, 32'h1111);
        bus.adc_rdn = 1'b1;
        bus.adc_wrn = 1'b1;
        tick(4);
        bus.adc_csn = 1'b1;
        tick(4);
        chk("rw_cfg", cfg_reg, 32'hABCD_1234);
        chk("rw_valid", valid_cnt, 32'd1);

        ch0 = 16'h7777; ch1 = 16'h8888; ch2 = 16'h9999;
        ch3 = 16'hAAAA; ch4 = 16'hBBBB; ch5 = 16'hCCCC;
        conv_start("conv3");
        n = 0;
        while (bus.adc_busy && n < 100) begin
            n++;
            tick(1);
        end
        bus.adc_standbyn = 1'b0;
        m = 0;
        while (bus.adc_busy && m < 10) begin
            m++;
            tick(1);
        end
        chk("stby_drop_fast", {31'd0, (m <= 3)}, 32'd1);
        chk("stby_busy", {31'd0, bus.adc_busy}, 32'd0);
        do_read(rd, rt);
        chk("stby_rd", {16'd0, rd}, 32'h2222);
        d0 = drop_cnt;
        bus.adc_conv = 1'b1;
        tick(4);
        bus.adc_conv = 1'b0;
        tick(4);
        chk("stby_conv_drop", drop_cnt - d0, 32'd1);
        chk("stby_no_busy", {31'd0, bus.adc_busy}, 32'd0);
        bus.adc_standbyn = 1'b1;
        tick(4);

        bus.adc_reset = 1'b1;
        tick(5);
        chk("devrst_cfg", cfg_reg, 32'h0000_03FF);
        bus.adc_reset = 1'b0;
        tick(4);
        do_read(rd, rt);
        chk("devrst_rd", {16'd0, rd}, 32'h0000);

        run_conv("conv4");
        do_write(16'h5A5A);
        do_write(16'hA5A5);
        chk("cfg2", cfg_reg, 32'h5A5A_A5A5);
        bus.adc_csn = 1'b0;
        tick(1);
        bus.adc_rdn = 1'b0;
        tick(4);
        chk("pre_rst_t", {31'd0, bus.adc_data_t}, 32'd0);
        chk("pre_rst_d", {16'd0, bus.adc_data_out}, 32'h7777);
        rst = 1'b1;
        #1;
        chk("rst_rel_t", {31'd0, bus.adc_data_t}, 32'd1);
        chk("rst_rel_d", {16'd0, bus.adc_data_out}, 32'h0000);
        chk("rst_cfg2", cfg_reg, 32'h0000_03FF);
        bus.adc_rdn = 1'b1;
        bus.adc_csn = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6);
        chk("post_rst_busy", {31'd0, bus.adc_busy}, 32'd0);
        do_read(rd, rt);
        chk("post_rst_t", {31'd0, rt}, 32'd0);
        chk("post_rst_rd", {16'd0, rd}, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
